// File: rtl/writeback_stage_if.sv
// Execute-to-writeback handshake and instruction bundle.
// The master side is execute; the slave side is the writeback stage.
interface writeback_stage_if;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic [3:0]  mem_addr;
  logic [15:0] result;
  logic        zero_in;
  logic        carry_in;
  logic        ac_in;
  logic        parity_in;

  modport master (
    output valid_in, opcode, rd, mem_addr, result,
    output zero_in, carry_in, ac_in, parity_in,
    input  ready_out
  );

  modport slave (
    input  valid_in, opcode, rd, mem_addr, result,
    input  zero_in, carry_in, ac_in, parity_in,
    output ready_out
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: registers execute results and applies register-file, memory,
// flag and halt side effects; MUL/DIV write their two result bytes over two cycles.
module writeback_stage #(
  parameter int unsigned RET_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  writeback_stage_if.slave ex,
  output logic             reg_we,
  output logic [2:0]       reg_waddr,
  output logic [7:0]       reg_wdata,
  output logic             mem_we,
  output logic [3:0]       mem_waddr,
  output logic [7:0]       mem_wdata,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             ac_flag,
  output logic             parity_flag,
  output logic             cmp_flag,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, HALT} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic [2:0] hi_addr;
  logic [7:0] hi_data;
  logic       is_muldiv, is_regwr, is_store, is_cmp, is_halt;
  logic       ld_zp, ld_c, ld_ac;

  assign is_muldiv = ex.opcode inside {5'b00011, 5'b00100};
  assign is_regwr  = ex.opcode inside {[5'b00000:5'b00010], [5'b00101:5'b01011],
                                       [5'b10000:5'b10101]};
  assign is_store  = (ex.opcode == 5'b01100);
  assign is_cmp    = (ex.opcode == 5'b11001);
  assign is_halt   = (ex.opcode == 5'b11111);
  assign ld_zp     = ex.opcode inside {[5'b00001:5'b01010], [5'b10000:5'b10101]};
  assign ld_c      = ex.opcode inside {5'b00001, 5'b00010, 5'b00101, 5'b00110,
                                       [5'b10000:5'b10011]};
  assign ld_ac     = ex.opcode inside {5'b00001, 5'b00010, 5'b00101, 5'b00110};

  assign ex.ready_out = (state == IDLE) || (state == WR_HI);
  assign accept       = ex.valid_in && ex.ready_out;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WR_HI: begin
        state_nxt = IDLE;
        if (accept) begin
          if (is_muldiv)    state_nxt = WR_LO;
          else if (is_halt) state_nxt = HALT;
        end
      end
      WR_LO:   state_nxt = WR_HI;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // The high byte is latched only for MUL/DIV so undefined upper result bits
  // from other ops can never propagate to reg_wdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_we      <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
      ac_flag     <= 1'b0;
      parity_flag <= 1'b0;
      cmp_flag    <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
      hi_addr     <= '0;
      hi_data     <= '0;
    end else begin
      reg_we <= 1'b0;
      mem_we <= 1'b0;
      if (state == WR_LO) begin
        reg_we    <= 1'b1;
        reg_waddr <= hi_addr;
        reg_wdata <= hi_data;
      end
      if (accept) begin
        retired <= retired + 1'b1;
        if (is_regwr || is_muldiv) begin
          reg_we    <= 1'b1;
          reg_waddr <= ex.rd;
          reg_wdata <= ex.result[7:0];
        end
        if (is_muldiv) begin
          hi_addr <= ex.rd + 3'd1;
          hi_data <= ex.result[15:8];
        end
        if (is_store) begin
          mem_we    <= 1'b1;
          mem_waddr <= ex.mem_addr;
          mem_wdata <= ex.result[7:0];
        end
        if (is_cmp)  cmp_flag <= ex.result[0];
        if (is_halt) halted   <= 1'b1;
        if (ld_zp || is_muldiv) begin
          zero_flag   <= ex.zero_in;
          parity_flag <= ex.parity_in;
        end
        if (ld_c)  carry_flag <= ex.carry_in;
        if (ld_ac) ac_flag    <= ex.ac_in;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model of pending writes.
module tb_writeback_stage;
  localparam int unsigned RET_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if bus();

  logic             reg_we, mem_we;
  logic [2:0]       reg_waddr;
  logic [7:0]       reg_wdata, mem_wdata;
  logic [3:0]       mem_waddr;
  logic             zero_flag, carry_flag, ac_flag, parity_flag, cmp_flag, halted;
  logic [RET_W-1:0] retired;

  writeback_stage #(.RET_W(RET_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex          (bus),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .ac_flag     (ac_flag),
    .parity_flag (parity_flag),
    .cmp_flag    (cmp_flag),
    .halted      (halted),
    .retired     (retired)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register writes still owed to the register file, oldest first.
  typedef struct packed { logic [2:0] a; logic [7:0] d; } wr_t;
  wr_t pend[$];
  bit               m_known = 0;
  logic             m_reg_we, m_mem_we;
  logic [2:0]       m_reg_waddr;
  logic [7:0]       m_reg_wdata, m_mem_wdata;
  logic [3:0]       m_mem_waddr;
  logic             m_z, m_c, m_ac, m_p, m_cmp, m_halted;
  logic [RET_W-1:0] m_ret;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_reg_we = 0; m_reg_waddr = 0; m_reg_wdata = 0;
    m_mem_we = 0; m_mem_waddr = 0; m_mem_wdata = 0;
    m_z = 0; m_c = 0; m_ac = 0; m_p = 0; m_cmp = 0; m_halted = 0; m_ret = 0;
    m_known = 1;
  endtask

  task automatic model_accept(input logic [4:0] op, input logic [2:0] r, input logic [3:0] ma,
                              input logic [15:0] res, input logic [3:0] fl);
    logic [2:0] r1;
    int code;
    code = int'(op);
    r1 = r + 3'd1;
    m_ret = m_ret + 1'b1;
    if (code == 3 || code == 4) begin
      pend.push_back('{a: r, d: res[7:0]});
      pend.push_back('{a: r1, d: res[15:8]});
    end else if (code <= 11 || (code >= 16 && code <= 21)) begin
      if (code != 12) pend.push_back('{a: r, d: res[7:0]});
    end
    if (code == 12) begin
      m_mem_we = 1; m_mem_waddr = ma; m_mem_wdata = res[7:0];
    end
    if (code == 25) m_cmp = res[0];
    if (code == 31) m_halted = 1;
    if ((code >= 1 && code <= 10) || (code >= 16 && code <= 21)) begin
      m_z = fl[3]; m_p = fl[0];
    end
    if (code == 1 || code == 2 || code == 5 || code == 6 || (code >= 16 && code <= 19))
      m_c = fl[2];
    if (code == 1 || code == 2 || code == 5 || code == 6) m_ac = fl[1];
  endtask

  // One clock: drive inputs, check ready, clock, advance the model, check outputs.
  task automatic cyc(input logic v, input logic [4:0] op, input logic [2:0] r,
                     input logic [3:0] ma, input logic [15:0] res, input logic [3:0] fl,
                     input logic rst);
    logic exp_ready;
    wr_t w;
    bus.valid_in = v; bus.opcode = op; bus.rd = r; bus.mem_addr = ma; bus.result = res;
    {bus.zero_in, bus.carry_in, bus.ac_in, bus.parity_in} = fl;
    reset = rst;
    exp_ready = (pend.size() == 0) && !m_halted;
    if (m_known) check("ready_out", bus.ready_out, exp_ready);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_reg_we = 0; m_mem_we = 0;
      if (v && exp_ready) model_accept(op, r, ma, res, fl);
      if (pend.size() > 0) begin
        w = pend.pop_front();
        m_reg_we = 1; m_reg_waddr = w.a; m_reg_wdata = w.d;
      end
    end
    #1;
    check("reg_we", reg_we, m_reg_we);
    check("reg_waddr", reg_waddr, m_reg_waddr);
    check("reg_wdata", reg_wdata, m_reg_wdata);
    check("mem_we", mem_we, m_mem_we);
    check("mem_waddr", mem_waddr, m_mem_waddr);
    check("mem_wdata", mem_wdata, m_mem_wdata);
    check("flags", {zero_flag, carry_flag, ac_flag, parity_flag, cmp_flag},
          {m_z, m_c, m_ac, m_p, m_cmp});
    check("halted", halted, m_halted);
    check("retired", retired, m_ret);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 3'd0, 4'd0, 16'h0000, 4'h0, 0);
  endtask

  initial begin
    logic [15:0] res;
    logic [4:0]  op;
    logic        v, rst;

    // Reset: all outputs low, ready high
    cyc(0, 5'd0, 3'd0, 4'd0, 16'h0000, 4'h0, 1);
    check("rst_ready", bus.ready_out, 1'b1);
    check("rst_retired", retired, 8'd0);

    // ADD r3 = A5, carry in
    cyc(1, 5'b00001, 3'd3, 4'd0, 16'h00A5, 4'b0100, 0);
    check("add_we", reg_we, 1'b1);
    check("add_waddr", reg_waddr, 3'd3);
    check("add_wdata", reg_wdata, 8'hA5);
    check("add_carry", carry_flag, 1'b1);
    idle(1);
    check("add_we_drop", reg_we, 1'b0);
    check("add_retired", retired, 8'd1);

    // MUL r7 with ADD queued behind it; high byte wraps to r0
    cyc(1, 5'b00011, 3'd7, 4'd0, 16'h1234, 4'b1001, 0);
    check("mul_lo", {reg_waddr, reg_wdata}, {3'd7, 8'h34});
    cyc(1, 5'b00001, 3'd2, 4'd0, 16'h0011, 4'b0000, 0);
    check("mul_hi", {reg_waddr, reg_wdata}, {3'd0, 8'h12});
    cyc(1, 5'b00001, 3'd2, 4'd0, 16'h0011, 4'b0000, 0);
    cyc(0, 5'd0, 3'd0, 4'd0, 16'h0000, 4'h0, 0);
    check("after_mul_add", {reg_waddr, reg_wdata}, {3'd2, 8'h11});

    // STORE with undefined upper result byte
    cyc(1, 5'b01100, 3'd1, 4'hC, {8'bx, 8'h5A}, 4'b1111, 0);
    check("store", {mem_we, mem_waddr, mem_wdata, reg_we}, {1'b1, 4'hC, 8'h5A, 1'b0});

    // COMPARE then BRANCH
    cyc(1, 5'b11001, 3'd0, 4'd0, {8'bx, 8'h01}, 4'b1111, 0);
    cyc(1, 5'b01110, 3'd0, 4'd0, {8'bx, 8'h00}, 4'b1111, 0);
    check("cmp_hold", cmp_flag, 1'b1);

    // HALT then keep offering work
    cyc(1, 5'b11111, 3'd0, 4'd0, {8'bx, 8'h00}, 4'h0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 5'b00001, 3'd4, 4'd0, 16'h0077, 4'hF, 0);
    check("halt_ready", bus.ready_out, 1'b0);
    check("halt_flag", halted, 1'b1);
    cyc(0, 5'd0, 3'd0, 4'd0, 16'h0000, 4'h0, 1);
    check("halt_rst_ready", bus.ready_out, 1'b1);

    // Reset during WR_LO of a DIV: high byte must never appear
    cyc(1, 5'b00100, 3'd5, 4'd0, 16'hBEEF, 4'h0, 0);
    cyc(0, 5'd0, 3'd0, 4'd0, 16'h0000, 4'h0, 1);
    check("div_rst_we", reg_we, 1'b0);
    idle(2);

    // Retired counter wrap with NOP-class opcode
    for (int i = 0; i < 260; i++) cyc(1, 5'b11010, 3'd0, 4'd0, 16'h0000, 4'h0, 0);
    check("retired_wrap", retired, 8'd4);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = 5'($urandom_range(0, 31));
      if (op == 5'b11111 && $urandom_range(0, 3) != 0) op = 5'b00010;
      rst = ($urandom_range(0, 39) == 0);
      res[7:0]  = 8'($urandom);
      res[15:8] = (op == 5'b00011 || op == 5'b00100) ? 8'($urandom) : 8'bx;
      cyc(v, op, 3'($urandom), 4'($urandom), res, 4'($urandom), rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
